// File: rtl/llc_snoop_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : llc_snoop_responder_if
// Description : Bus, tag-array, L1 and writeback signals of the LLC snoop
//               responder, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface llc_snoop_responder_if #(
    parameter int ADDRESS_SIZE = 32
);
    logic                    bus_valid;
    logic                    bus_ready;
    logic [2:0]              bus_op;
    logic [ADDRESS_SIZE-1:0] bus_addr;
    logic                    tag_req;
    logic [ADDRESS_SIZE-1:0] tag_addr;
    logic                    tag_rsp_valid;
    logic                    tag_hit;
    logic [1:0]              tag_mesi;
    logic                    tag_wr_en;
    logic [1:0]              tag_wr_mesi;
    logic                    snoop_valid;
    logic [1:0]              snoop_result;
    logic                    l1_msg_valid;
    logic [1:0]              l1_msg;
    logic                    wb_req;
    logic [ADDRESS_SIZE-1:0] wb_addr;
    logic                    wb_ack;
    logic                    protocol_err;
    logic                    busy;

    modport slave (
        input  bus_valid, bus_op, bus_addr, tag_rsp_valid, tag_hit, tag_mesi, wb_ack,
        output bus_ready, tag_req, tag_addr, tag_wr_en, tag_wr_mesi, snoop_valid,
               snoop_result, l1_msg_valid, l1_msg, wb_req, wb_addr, protocol_err, busy
    );

    modport master (
        output bus_valid, bus_op, bus_addr, tag_rsp_valid, tag_hit, tag_mesi, wb_ack,
        input  bus_ready, tag_req, tag_addr, tag_wr_en, tag_wr_mesi, snoop_valid,
               snoop_result, l1_msg_valid, l1_msg, wb_req, wb_addr, protocol_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/llc_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : llc_snoop_responder
// Description : Snoop responder for the shared LLC bus: looks up the local
//               tag/MESI array, answers HIT/HITM/NOHIT, issues L1 messages,
//               performs the HITM writeback and updates the MESI state.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_snoop_responder #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int LINE_OFFSET_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    llc_snoop_responder_if.slave  sif
);
    localparam logic [2:0] c_OP_READ  = 3'd1;
    localparam logic [2:0] c_OP_WRITE = 3'd2;
    localparam logic [2:0] c_OP_INV   = 3'd3;
    localparam logic [2:0] c_OP_RWIM  = 3'd4;

    localparam logic [1:0] c_MESI_I = 2'd0;
    localparam logic [1:0] c_MESI_S = 2'd1;
    localparam logic [1:0] c_MESI_E = 2'd2;
    localparam logic [1:0] c_MESI_M = 2'd3;

    localparam logic [1:0] c_RES_HIT   = 2'd0;
    localparam logic [1:0] c_RES_HITM  = 2'd1;
    localparam logic [1:0] c_RES_NOHIT = 2'd2;

    localparam logic [1:0] c_MSG_NONE    = 2'd0;
    localparam logic [1:0] c_MSG_GETLINE = 2'd1;
    localparam logic [1:0] c_MSG_INVLINE = 2'd2;
    localparam logic [1:0] c_MSG_EVICT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_WB   = 3'd4,
        ST_UPD  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_op;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [1:0]              r_eff;
    logic [1:0]              r_next;
    logic [1:0]              r_result;
    logic [1:0]              r_msg;
    logic                    r_err;

    logic [1:0] w_eff;
    logic [1:0] w_next;
    logic [1:0] w_result;
    logic [1:0] w_msg;
    logic       w_err;

    logic       w_bus_ready;
    logic       w_tag_req;
    logic       w_snoop_valid;
    logic       w_l1_valid;
    logic [1:0] w_l1_msg;
    logic       w_err_pulse;
    logic       w_wb_req;
    logic       w_tag_wr_en;
    logic [1:0] w_tag_wr_mesi;

    // Snoop decision table; a miss is treated as state I regardless of tag_mesi.
    always_comb begin
        w_eff    = sif.tag_hit ? sif.tag_mesi : c_MESI_I;
        w_next   = w_eff;
        w_result = c_RES_NOHIT;
        w_msg    = c_MSG_NONE;
        w_err    = 1'b0;
        case (r_op)
            c_OP_READ: begin
                case (w_eff)
                    c_MESI_M: begin
                        w_result = c_RES_HITM;
                        w_next   = c_MESI_S;
                        w_msg    = c_MSG_GETLINE;
                    end
                    c_MESI_E, c_MESI_S: begin
                        w_result = c_RES_HIT;
                        w_next   = c_MESI_S;
                    end
                    default: ;
                endcase
            end
            c_OP_RWIM: begin
                case (w_eff)
                    c_MESI_M: begin
                        w_result = c_RES_HITM;
                        w_next   = c_MESI_I;
                        w_msg    = c_MSG_EVICT;
                    end
                    c_MESI_E, c_MESI_S: begin
                        w_result = c_RES_HIT;
                        w_next   = c_MESI_I;
                        w_msg    = c_MSG_INVLINE;
                    end
                    default: ;
                endcase
            end
            c_OP_INV: begin
                case (w_eff)
                    c_MESI_S: begin
                        w_result = c_RES_HIT;
                        w_next   = c_MESI_I;
                        w_msg    = c_MSG_INVLINE;
                    end
                    c_MESI_E, c_MESI_M: w_err = 1'b1;
                    default: ;
                endcase
            end
            c_OP_WRITE: w_err = (w_eff == c_MESI_M);
            default:    w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bus_ready   = 1'b0;
        w_tag_req     = 1'b0;
        w_snoop_valid = 1'b0;
        w_l1_valid    = 1'b0;
        w_l1_msg      = c_MSG_NONE;
        w_err_pulse   = 1'b0;
        w_wb_req      = 1'b0;
        w_tag_wr_en   = 1'b0;
        w_tag_wr_mesi = c_MESI_I;
        case (r_state)
            ST_IDLE: begin
                w_bus_ready = 1'b1;
                if (sif.bus_valid) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_tag_req   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sif.tag_rsp_valid) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_snoop_valid = 1'b1;
                w_l1_valid    = (r_msg != c_MSG_NONE);
                w_l1_msg      = r_msg;
                w_err_pulse   = r_err;
                w_state_nxt   = (r_result == c_RES_HITM) ? ST_WB : ST_UPD;
            end
            ST_WB: begin
                w_wb_req = 1'b1;
                if (sif.wb_ack) w_state_nxt = ST_UPD;
            end
            ST_UPD: begin
                if (r_next != r_eff) begin
                    w_tag_wr_en   = 1'b1;
                    w_tag_wr_mesi = r_next;
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'd0;
            r_addr   <= '0;
            r_eff    <= c_MESI_I;
            r_next   <= c_MESI_I;
            r_result <= c_RES_NOHIT;
            r_msg    <= c_MSG_NONE;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && sif.bus_valid) begin
                r_op   <= sif.bus_op;
                r_addr <= sif.bus_addr;
            end
            if (r_state == ST_WAIT && sif.tag_rsp_valid) begin
                r_eff    <= w_eff;
                r_next   <= w_next;
                r_result <= w_result;
                r_msg    <= w_msg;
                r_err    <= w_err;
            end
        end
    end

    assign sif.bus_ready    = w_bus_ready;
    assign sif.tag_req      = w_tag_req;
    assign sif.tag_addr     = r_addr;
    assign sif.tag_wr_en    = w_tag_wr_en;
    assign sif.tag_wr_mesi  = w_tag_wr_mesi;
    assign sif.snoop_valid  = w_snoop_valid;
    assign sif.snoop_result = r_result;
    assign sif.l1_msg_valid = w_l1_valid;
    assign sif.l1_msg       = w_l1_msg;
    assign sif.wb_req       = w_wb_req;
    assign sif.wb_addr      = {r_addr[ADDRESS_SIZE-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    assign sif.protocol_err = w_err_pulse;
    assign sif.busy         = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_llc_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_snoop_responder
// Description : Directed scoreboard bench for llc_snoop_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_snoop_responder;
    typedef struct {
        logic [1:0]  res;
        logic        mv;
        logic [1:0]  msg;
        logic        err;
        logic        wr;
        logic [1:0]  wm;
        logic        wb;
        logic [31:0] wa;
        int          lat;
        logic        abort;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   n_snoop;
    logic t_hit;
    logic [1:0] t_mesi;
    logic ack_en;
    exp_t q[$];

    llc_snoop_responder_if #(.ADDRESS_SIZE(32)) sif ();

    llc_snoop_responder #(
        .ADDRESS_SIZE     (32),
        .LINE_OFFSET_BITS (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sif.snoop_valid) n_snoop <= n_snoop + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic exp_t mk(input logic [1:0] res, input logic [1:0] msg, input logic err,
                                input logic wr, input logic [1:0] wm, input logic wb,
                                input logic [31:0] wa, input int lat, input logic abort);
        exp_t e;
        e.res = res; e.mv = (msg != 2'd0); e.msg = msg; e.err = err;
        e.wr = wr; e.wm = wm; e.wb = wb; e.wa = wa; e.lat = lat; e.abort = abort;
        return e;
    endfunction

    // Tag array model: answer one cycle after each lookup request.
    initial begin : tag_model
        forever begin
            @(negedge clk);
            if (sif.tag_req) begin
                @(posedge clk); #2;
                sif.tag_rsp_valid = 1'b1; sif.tag_hit = t_hit; sif.tag_mesi = t_mesi;
                @(posedge clk); #2;
                sif.tag_rsp_valid = 1'b0; sif.tag_hit = 1'b0; sif.tag_mesi = 2'd0;
            end
        end
    end

    // Bus writeback model: acknowledge three cycles after wb_req rises.
    initial begin : wb_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt = sif.wb_req ? cnt + 1 : 0;
            if (cnt == 3 && ack_en) begin
                @(posedge clk); #2; sif.wb_ack = 1'b1;
                @(posedge clk); #2; sif.wb_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int n, k, nwr, nwb;
        logic [1:0] wm;
        logic got;
        @(negedge clk);
        forever begin
            if (rst_n && sif.bus_valid && sif.bus_ready) begin
                n = cyc + 1; got = 1'b0; k = 0;
                @(negedge clk);
                while (!sif.snoop_valid && k < 20) begin @(negedge clk); k++; end
                if (!sif.snoop_valid) fail_now("snoop_wait");
                else if (q.size() == 0) fail_now("unexpected_snoop");
                else begin
                    e = q.pop_front(); got = 1'b1;
                    chk("snoop_result", sif.snoop_result, e.res);
                    chk("l1_msg_valid", sif.l1_msg_valid, e.mv);
                    if (e.mv) chk("l1_msg", sif.l1_msg, e.msg);
                    chk("protocol_err", sif.protocol_err, e.err);
                    if (!e.abort) chk("resp_cycle", cyc, n + 2);
                end
                nwr = 0; nwb = 0; wm = 2'd0; k = 0;
                while (!sif.bus_ready && k < 60) begin
                    if (sif.tag_wr_en) begin nwr++; wm = sif.tag_wr_mesi; end
                    if (sif.wb_req) begin
                        nwb++;
                        if (got && !e.abort && e.wb) chk("wb_addr", sif.wb_addr, e.wa);
                    end
                    @(negedge clk); k++;
                end
                if (!sif.bus_ready) fail_now("ready_wait");
                else if (got && !e.abort) begin
                    chk("tag_wr_count", nwr, e.wr ? 1 : 0);
                    if (e.wr) chk("tag_wr_mesi", wm, e.wm);
                    chk("wb_seen", (nwb > 0), e.wb);
                    chk("ready_cycle", cyc, n + e.lat);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic hit,
                         input logic [1:0] mesi, input exp_t e);
        int k;
        t_hit = hit; t_mesi = mesi;
        q.push_back(e);
        @(posedge clk); #2;
        sif.bus_valid = 1'b1; sif.bus_op = op; sif.bus_addr = addr;
        k = 0;
        @(negedge clk);
        while (!sif.bus_ready && k < 50) begin @(negedge clk); k++; end
        if (!sif.bus_ready) fail_now("accept_wait");
        @(posedge clk); #2;
        sif.bus_valid = 1'b0; sif.bus_op = 3'($urandom); sif.bus_addr = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!sif.bus_ready && k < 80) begin @(negedge clk); k++; end
        if (!sif.bus_ready) fail_now("idle_wait");
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k, s0;
        cyc = 0; total = 0; bad = 0; n_snoop = 0;
        t_hit = 1'b0; t_mesi = 2'd0; ack_en = 1'b1;
        rst_n = 1'b0;
        sif.bus_valid = 1'b0; sif.bus_op = 3'd0; sif.bus_addr = 32'd0;
        sif.tag_rsp_valid = 1'b0; sif.tag_hit = 1'b0; sif.tag_mesi = 2'd0; sif.wb_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_ready", sif.bus_ready, 1);
        chk("rst_snoop_result", sif.snoop_result, 2);
        chk("rst_tag_req", sif.tag_req, 0);
        chk("rst_wb_req", sif.wb_req, 0);
        chk("rst_tag_addr", sif.tag_addr, 0);
        chk("rst_wb_addr", sif.wb_addr, 0);
        chk("rst_busy", sif.busy, 0);
        @(posedge clk); #2; rst_n = 1'b1;

        // READ/E -> HIT, S
        issue(3'd1, 32'h0000_1234, 1'b1, 2'd2, mk(2'd0, 2'd0, 0, 1, 2'd1, 0, 0, 4, 0));
        @(negedge clk);
        chk("req_tag_addr", sif.tag_addr, 32'h0000_1234);
        wait_idle();
        // RWIM/M -> HITM, EVICTLINE, writeback, I
        issue(3'd4, 32'h0000_ABCD, 1'b1, 2'd3, mk(2'd1, 2'd3, 0, 1, 2'd0, 1, 32'h0000_ABC0, 8, 0));
        wait_idle();
        // INVALIDATE/S and INVALIDATE/E
        issue(3'd3, 32'h0000_2000, 1'b1, 2'd1, mk(2'd0, 2'd2, 0, 1, 2'd0, 0, 0, 4, 0));
        wait_idle();
        issue(3'd3, 32'h0000_2040, 1'b1, 2'd2, mk(2'd2, 2'd0, 1, 0, 2'd0, 0, 0, 4, 0));
        wait_idle();
        // Miss with stale M in tag_mesi is treated as I
        issue(3'd1, 32'h0000_3000, 1'b0, 2'd3, mk(2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 4, 0));
        wait_idle();
        // READ/M -> HITM, GETLINE, writeback, S
        issue(3'd1, 32'h1234_567F, 1'b1, 2'd3, mk(2'd1, 2'd1, 0, 1, 2'd1, 1, 32'h1234_5640, 8, 0));
        wait_idle();
        // WRITE/M is illegal; WRITE/E is silent
        issue(3'd2, 32'h0000_4000, 1'b1, 2'd3, mk(2'd2, 2'd0, 1, 0, 2'd0, 0, 0, 4, 0));
        wait_idle();
        issue(3'd2, 32'h0000_4040, 1'b1, 2'd2, mk(2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 4, 0));
        wait_idle();

        // Op 6 with bus_valid held; a READ follows once the responder is idle
        t_hit = 1'b1; t_mesi = 2'd1;
        q.push_back(mk(2'd2, 2'd0, 1, 0, 2'd0, 0, 0, 4, 0));
        q.push_back(mk(2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 4, 0));
        s0 = n_snoop;
        @(posedge clk); #2;
        sif.bus_valid = 1'b1; sif.bus_op = 3'd6; sif.bus_addr = 32'h0000_0100;
        @(negedge clk);
        @(posedge clk); #2;
        sif.bus_op = 3'd1; sif.bus_addr = 32'h0000_0200;
        k = 0;
        @(negedge clk);
        while (!sif.bus_ready && k < 50) begin @(negedge clk); k++; end
        if (!sif.bus_ready) fail_now("held_accept_wait");
        @(posedge clk); #2;
        sif.bus_valid = 1'b0;
        wait_idle();
        chk("held_snoop_pulses", n_snoop - s0, 2);

        // Asynchronous reset during writeback
        ack_en = 1'b0;
        issue(3'd4, 32'h0000_5000, 1'b1, 2'd3, mk(2'd1, 2'd3, 0, 0, 2'd0, 0, 0, 0, 1));
        k = 0;
        @(negedge clk);
        while (!sif.wb_req && k < 20) begin @(negedge clk); k++; end
        if (!sif.wb_req) fail_now("wb_wait");
        #1 rst_n = 1'b0;
        #1;
        chk("arst_wb_req", sif.wb_req, 0);
        chk("arst_bus_ready", sif.bus_ready, 1);
        chk("arst_snoop_result", sif.snoop_result, 2);
        @(posedge clk); #2;
        rst_n = 1'b1; ack_en = 1'b1;
        issue(3'd1, 32'h0000_6000, 1'b1, 2'd1, mk(2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 4, 0));
        wait_idle();

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
